multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 43 ++++
 rtl/multicycle_controller_alu_op_decode.sv | 25 ++
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcode and
// funct fields, ALU operation codes and PC source selects.
package multicycle_controller_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StHalt
   } state_e;

   // Opcodes, instr[31:26]
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpHalt  = 6'b111111;

   // R-type funct codes, instr[5:0]
   localparam logic [5:0] FnAnd = 6'b100100;
   localparam logic [5:0] FnOr  = 6'b100101;
   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnSlt = 6'b101010;
   localparam logic [5:0] FnNor = 6'b100111;

   // ALU operation codes
   localparam logic [3:0] AluAnd = 4'b0000;
   localparam logic [3:0] AluOr  = 4'b0001;
   localparam logic [3:0] AluAdd = 4'b0010;
   localparam logic [3:0] AluSub = 4'b0110;
   localparam logic [3:0] AluSlt = 4'b0111;
   localparam logic [3:0] AluNor = 4'b1100;

   // PC source selects
   localparam logic [1:0] PcSrcSeq    = 2'b00;  // PC + 1
   localparam logic [1:0] PcSrcBranch = 2'b01;  // PC + 1 + imm

endpackage

// File: rtl/multicycle_controller_alu_op_decode.sv
// R-type funct to ALU operation decoder; valid_o flags a recognised funct.
module alu_op_decode
   import multicycle_controller_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [3:0] alu_op_o,
   output logic       valid_o
);

   // Table lookup; unknown functs yield AND with valid_o low
   always_comb begin
      alu_op_o = AluAnd;
      valid_o  = 1'b1;
      case (funct_i)
         FnAnd:   alu_op_o = AluAnd;
         FnOr:    alu_op_o = AluOr;
         FnAdd:   alu_op_o = AluAdd;
         FnSub:   alu_op_o = AluSub;
         FnSlt:   alu_op_o = AluSlt;
         FnNor:   alu_op_o = AluNor;
         default: valid_o  = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a bus
// wait timeout, sticky illegal/bus_error flags and a terminal HALT state.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        start,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [31:0] instr,
   input  logic        dmem_ready,
   input  logic        alu_zero,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        ir_write,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src,
   output logic [3:0]  alu_op,
   output logic        mem_read,
   output logic        mem_write,
   output logic        busy,
   output logic        halted,
   output logic        illegal,
   output logic        bus_error
);

   localparam int unsigned WaitW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

   state_e           state_q, state_d;
   logic [5:0]       opcode_q, opcode_d;
   logic [5:0]       funct_q, funct_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic             illegal_q, illegal_d;
   logic             bus_error_q, bus_error_d;

   logic [3:0] rtype_alu_op;
   logic       rtype_valid;
   logic       wait_hit;
   logic       unused_instr;

   assign unused_instr = ^instr[25:6];

   // Current cycle is the MEM_WAIT_MAX-th consecutive cycle without ready
   assign wait_hit = (32'(wait_q) + 32'd1) == MEM_WAIT_MAX;

   alu_op_decode u_alu_op_decode (
      .funct_i  (funct_q),
      .alu_op_o (rtype_alu_op),
      .valid_o  (rtype_valid)
   );

   // State register
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched instruction fields, wait counter and sticky error flags
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         opcode_q    <= '0;
         funct_q     <= '0;
         wait_q      <= '0;
         illegal_q   <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         opcode_q    <= opcode_d;
         funct_q     <= funct_d;
         wait_q      <= wait_d;
         illegal_q   <= illegal_d;
         bus_error_q <= bus_error_d;
      end
   end

   // Next-state and register update logic
   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      funct_d     = funct_q;
      wait_d      = '0;
      illegal_d   = illegal_q;
      bus_error_d = bus_error_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StFetch;
         end
         StFetch: begin
            if (imem_ready) begin
               opcode_d = instr[31:26];
               funct_d  = instr[5:0];
               state_d  = StDecode;
            end else if (wait_hit) begin
               bus_error_d = 1'b1;
               state_d     = StHalt;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StDecode: begin
            case (opcode_q)
               OpRtype: begin
                  if (rtype_valid) begin
                     state_d = StExec;
                  end else begin
                     illegal_d = 1'b1;
                     state_d   = StFetch;
                  end
               end
               OpLw, OpSw, OpAddi, OpBeq: state_d = StExec;
               OpHalt:                    state_d = StHalt;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = StFetch;
               end
            endcase
         end
         StExec: begin
            case (opcode_q)
               OpLw, OpSw:      state_d = StMem;
               OpRtype, OpAddi: state_d = StWb;
               default:         state_d = StFetch;
            endcase
         end
         StMem: begin
            if (dmem_ready) begin
               state_d = (opcode_q == OpLw) ? StWb : StFetch;
            end else if (wait_hit) begin
               bus_error_d = 1'b1;
               state_d     = StHalt;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StWb:    state_d = StFetch;
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   // Control outputs decoded from state and latched fields
   always_comb begin
      imem_req   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PcSrcSeq;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      alu_op     = AluAnd;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      busy       = (state_q != StIdle) && (state_q != StHalt);
      halted     = (state_q == StHalt);
      illegal    = illegal_q;
      bus_error  = bus_error_q;
      unique case (state_q)
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               pc_src   = PcSrcSeq;
            end
         end
         StExec: begin
            case (opcode_q)
               OpLw, OpSw, OpAddi: begin
                  alu_src = 1'b1;
                  alu_op  = AluAdd;
               end
               OpRtype: alu_op = rtype_alu_op;
               OpBeq: begin
                  alu_op = AluSub;
                  if (alu_zero) begin
                     pc_write = 1'b1;
                     pc_src   = PcSrcBranch;
                  end
               end
               default: ;
            endcase
         end
         StMem: begin
            mem_read  = (opcode_q == OpLw);
            mem_write = (opcode_q == OpSw);
         end
         StWb: begin
            reg_write  = 1'b1;
            reg_dst    = (opcode_q == OpRtype);
            mem_to_reg = (opcode_q == OpLw);
         end
         default: ;
      endcase
   end

endmodule
